// File: rtl/wb_pkg.sv
// Shared types and helpers for the writeback result buffer.
package wb_pkg;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned DES_W   = 4;
    localparam int unsigned BR_W    = 3;
    localparam int unsigned REG_NUM = 16;

    // One buffer slot; entries beyond count are held all-zero.
    typedef struct packed {
        logic              vld;
        logic              done;
        logic [DES_W-1:0]  des;
        logic [DATA_W-1:0] data;
        logic [BR_W-1:0]   branch;
    } wb_entry_t;

    // One-hot register mask for a destination index.
    function automatic logic [REG_NUM-1:0] des_onehot(input logic [DES_W-1:0] des);
        des_onehot = REG_NUM'(1) << des;
    endfunction

endpackage

// File: rtl/wb_compact.sv
// Order-preserving gather: kept entries first, then kept append lanes.
module wb_compact
    import wb_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned LANES = 4,
    parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  wb_entry_t        i_ent      [DEPTH],
    input  logic [DEPTH-1:0] i_keep,
    input  wb_entry_t        i_app      [LANES],
    input  logic [LANES-1:0] i_app_keep,
    output wb_entry_t        o_ent      [DEPTH],
    output logic [CNT_W-1:0] o_count
);

    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [CNT_W-1:0] w_pos;

    // Running prefix count places each kept source in the next free slot.
    always_comb begin
        o_ent = '{default: '0};
        w_pos = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (i_keep[i]) begin
                if (w_pos < CNT_W'(DEPTH)) o_ent[IDX_W'(w_pos)] = i_ent[i];
                w_pos = w_pos + CNT_W'(1);
            end
        end
        for (int l = 0; l < LANES; l++) begin
            if (i_app_keep[l]) begin
                if (w_pos < CNT_W'(DEPTH)) o_ent[IDX_W'(w_pos)] = i_app[l];
                w_pos = w_pos + CNT_W'(1);
            end
        end
        o_count = w_pos;
    end

endmodule

// File: rtl/wb_result_buffer.sv
// In-order retiring result buffer between execute lanes and register writeback.
module wb_result_buffer
    import wb_pkg::*;
#(
    parameter int unsigned LANES = 4,
    parameter int unsigned DEPTH = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [LANES-1:0]        in_vld,
    input  logic [LANES*DES_W-1:0]  in_des,
    input  logic [LANES*DATA_W-1:0] in_data,
    input  logic [LANES*BR_W-1:0]   in_branch,
    input  logic [LANES-1:0]        in_is_load,
    output logic                    in_rdy,
    input  logic                    load_done,
    input  logic [DATA_W-1:0]       load_data,
    input  logic                    flush_en,
    input  logic [BR_W-1:0]         flush_id,
    output logic [LANES-1:0]        out_vld,
    output logic [LANES*DES_W-1:0]  out_des,
    output logic [LANES*DATA_W-1:0] out_data,
    input  logic [LANES-1:0]        out_rdy,
    output logic                    buffer_full,
    output logic                    buffer_empty,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic [REG_NUM-1:0]      reg_busy
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    wb_entry_t          r_ent [DEPTH];
    logic [CNT_W-1:0]   r_count;
    logic               r_in_rdy;
    logic               r_full;
    logic               r_empty;
    logic [REG_NUM-1:0] r_busy;

    wb_entry_t          w_ent [DEPTH];
    wb_entry_t          w_app [LANES];
    wb_entry_t          w_nxt [DEPTH];
    logic               w_pend_seen;
    logic               w_prefix;
    logic               w_ret_ok;
    logic [LANES-1:0]   w_out_vld;
    logic [LANES-1:0]   w_ret;
    logic [DEPTH-1:0]   w_keep;
    logic [LANES-1:0]   w_app_keep;
    logic [CNT_W-1:0]   w_cnt;
    logic [REG_NUM-1:0] w_busy_nxt;

    assign in_rdy       = r_in_rdy;
    assign buffer_full  = r_full;
    assign buffer_empty = r_empty;
    assign count        = r_count;
    assign reg_busy     = r_busy;
    assign out_vld      = w_out_vld;

    // Load fill: the oldest entry still waiting takes the memory response.
    always_comb begin
        w_pend_seen = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            w_ent[i] = r_ent[i];
            if (!w_pend_seen && r_ent[i].vld && !r_ent[i].done) begin
                w_pend_seen = 1'b1;
                if (load_done) begin
                    w_ent[i].done = 1'b1;
                    w_ent[i].data = load_data;
                end
            end
        end
    end

    // Output lanes present the oldest entries; valid only over a done prefix.
    always_comb begin
        w_prefix  = 1'b1;
        w_out_vld = '0;
        out_des   = '0;
        out_data  = '0;
        for (int k = 0; k < LANES; k++) begin
            w_prefix     = w_prefix & r_ent[k].vld & r_ent[k].done;
            w_out_vld[k] = w_prefix & ~(flush_en && (r_ent[k].branch == flush_id));
            out_des[k*DES_W +: DES_W]    = r_ent[k].des;
            out_data[k*DATA_W +: DATA_W] = r_ent[k].data;
        end
    end

    // Drain retires a contiguous run of accepted lanes starting at lane 0.
    always_comb begin
        w_ret_ok = 1'b1;
        w_ret    = '0;
        for (int k = 0; k < LANES; k++) begin
            w_ret_ok = w_ret_ok & w_out_vld[k] & out_rdy[k];
            w_ret[k] = w_ret_ok;
        end
    end

    // Survivors: held entries neither retired nor squashed.
    always_comb begin
        w_keep = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_keep[i] = w_ent[i].vld && !(flush_en && (w_ent[i].branch == flush_id));
        end
        for (int k = 0; k < LANES; k++) begin
            if (w_ret[k]) w_keep[k] = 1'b0;
        end
    end

    // Incoming lanes become entries; loads start not-done with zero data.
    always_comb begin
        w_app_keep = '0;
        for (int l = 0; l < LANES; l++) begin
            w_app[l].vld    = 1'b1;
            w_app[l].done   = !in_is_load[l];
            w_app[l].des    = in_des[l*DES_W +: DES_W];
            w_app[l].data   = in_is_load[l] ? '0 : in_data[l*DATA_W +: DATA_W];
            w_app[l].branch = in_branch[l*BR_W +: BR_W];
            w_app_keep[l]   = r_in_rdy && in_vld[l]
                              && !(flush_en && (in_branch[l*BR_W +: BR_W] == flush_id));
        end
    end

    wb_compact #(
        .DEPTH (DEPTH),
        .LANES (LANES),
        .CNT_W (CNT_W)
    ) u_compact (
        .i_ent      (w_ent),
        .i_keep     (w_keep),
        .i_app      (w_app),
        .i_app_keep (w_app_keep),
        .o_ent      (w_nxt),
        .o_count    (w_cnt)
    );

    // Busy bitmap of the next-cycle contents.
    always_comb begin
        w_busy_nxt = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_nxt[i].vld) w_busy_nxt = w_busy_nxt | des_onehot(w_nxt[i].des);
        end
    end

    // State and flag registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) r_ent[i] <= '0;
            r_count  <= '0;
            r_in_rdy <= 1'b1;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
            r_busy   <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) r_ent[i] <= w_nxt[i];
            r_count  <= w_cnt;
            r_in_rdy <= (CNT_W'(DEPTH) - w_cnt) >= CNT_W'(LANES);
            r_full   <= w_cnt > CNT_W'(DEPTH - LANES);
            r_empty  <= w_cnt == '0;
            r_busy   <= w_busy_nxt;
        end
    end

endmodule

// File: tb/tb_wb_result_buffer.sv
// Directed bench for wb_result_buffer with a drain scoreboard.
module tb_wb_result_buffer;

    localparam int LANES = 4;
    localparam int DEPTH = 8;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [LANES-1:0]      in_vld;
    logic [LANES*4-1:0]    in_des;
    logic [LANES*32-1:0]   in_data;
    logic [LANES*3-1:0]    in_branch;
    logic [LANES-1:0]      in_is_load;
    logic                  in_rdy;
    logic                  load_done;
    logic [31:0]           load_data;
    logic                  flush_en;
    logic [2:0]            flush_id;
    logic [LANES-1:0]      out_vld;
    logic [LANES*4-1:0]    out_des;
    logic [LANES*32-1:0]   out_data;
    logic [LANES-1:0]      out_rdy;
    logic                  buffer_full;
    logic                  buffer_empty;
    logic [3:0]            count;
    logic [15:0]           reg_busy;

    int n_cmp = 0;
    int n_bad = 0;
    logic [3:0]  q_des  [$];
    logic [31:0] q_data [$];

    wb_result_buffer #(.LANES(LANES), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .in_vld(in_vld), .in_des(in_des), .in_data(in_data),
        .in_branch(in_branch), .in_is_load(in_is_load), .in_rdy(in_rdy),
        .load_done(load_done), .load_data(load_data),
        .flush_en(flush_en), .flush_id(flush_id),
        .out_vld(out_vld), .out_des(out_des), .out_data(out_data),
        .out_rdy(out_rdy),
        .buffer_full(buffer_full), .buffer_empty(buffer_empty),
        .count(count), .reg_busy(reg_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h", nm, act, exp);
        end
    endtask

    task automatic idle();
        in_vld = '0; in_des = '0; in_data = '0; in_branch = '0; in_is_load = '0;
        load_done = 1'b0; load_data = '0; flush_en = 1'b0; flush_id = '0;
        out_rdy = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic lane(input int l, input logic [3:0] d, input logic [31:0] v,
                        input logic [2:0] b, input logic ld);
        in_vld[l]            = 1'b1;
        in_des[l*4 +: 4]     = d;
        in_data[l*32 +: 32]  = v;
        in_branch[l*3 +: 3]  = b;
        in_is_load[l]        = ld;
    endtask

    task automatic push(input logic [3:0] d, input logic [31:0] v);
        q_des.push_back(d);
        q_data.push_back(v);
    endtask

    // Monitor: every lane that will retire at the coming edge is checked in order.
    always @(negedge clk) begin
        logic ok;
        logic [3:0]  ed;
        logic [31:0] ev;
        if (!rst) begin
            ok = 1'b1;
            for (int k = 0; k < LANES; k++) begin
                ok = ok && out_vld[k] && out_rdy[k];
                if (ok) begin
                    if (q_des.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL drain_unexpected lane %0d: got des %h data %h, required none",
                                 k, out_des[k*4 +: 4], out_data[k*32 +: 32]);
                    end else begin
                        ed = q_des.pop_front();
                        ev = q_data.pop_front();
                        chk("drain_des", 32'(out_des[k*4 +: 4]), 32'(ed));
                        chk("drain_data", out_data[k*32 +: 32], ev);
                    end
                end
            end
        end
    end

    initial begin
        idle();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // reset state
        chk("rst_count", 32'(count), 0);
        chk("rst_empty", 32'(buffer_empty), 1);
        chk("rst_full", 32'(buffer_full), 0);
        chk("rst_in_rdy", 32'(in_rdy), 1);
        chk("rst_busy", 32'(reg_busy), 0);
        chk("rst_out_vld", 32'(out_vld), 0);

        // compaction of sparse lanes
        lane(1, 4'd5, 32'hA, 3'd0, 1'b0);
        lane(3, 4'd9, 32'hB, 3'd0, 1'b0);
        push(4'd5, 32'hA); push(4'd9, 32'hB);
        tick();
        chk("cmp_count", 32'(count), 2);
        chk("cmp_out_vld", 32'(out_vld), 32'h3);
        chk("cmp_des0", 32'(out_des[3:0]), 5);
        chk("cmp_des1", 32'(out_des[7:4]), 9);
        chk("cmp_busy", 32'(reg_busy), 32'h0220);
        out_rdy = '1;
        tick();
        chk("cmp_drained", 32'(count), 0);
        chk("cmp_busy_clr", 32'(reg_busy), 0);

        // load ordering and fill latency
        lane(0, 4'd2, 32'h0, 3'd0, 1'b1);
        lane(1, 4'd3, 32'h33, 3'd0, 1'b0);
        push(4'd2, 32'h1234); push(4'd3, 32'h33);
        tick();
        chk("ld_out_vld0", 32'(out_vld), 0);
        chk("ld_busy", 32'(reg_busy), 32'h000C);
        load_done = 1'b1; load_data = 32'h1234;
        #1 chk("ld_no_bypass", 32'(out_vld), 0);
        tick();
        chk("ld_out_vld1", 32'(out_vld), 32'h3);
        chk("ld_data0", out_data[31:0], 32'h1234);
        out_rdy = 4'b0001;
        tick();
        chk("ld_count", 32'(count), 1);
        chk("ld_remain_des", 32'(out_des[3:0]), 3);
        out_rdy = '1;
        tick();
        chk("ld_drained", 32'(count), 0);

        // full / backpressure
        for (int l = 0; l < 4; l++) begin
            lane(l, 4'(l + 1), 32'h100 + 32'(l + 1), 3'd0, 1'b0);
            push(4'(l + 1), 32'h100 + 32'(l + 1));
        end
        tick();
        chk("full_c4", 32'(count), 4);
        chk("full_rdy4", 32'(in_rdy), 1);
        chk("full_flag4", 32'(buffer_full), 0);
        lane(0, 4'd6, 32'h106, 3'd0, 1'b0);
        push(4'd6, 32'h106);
        tick();
        chk("full_c5", 32'(count), 5);
        chk("full_rdy5", 32'(in_rdy), 0);
        chk("full_flag5", 32'(buffer_full), 1);
        for (int l = 0; l < 4; l++) lane(l, 4'hF, 32'hBAD, 3'd0, 1'b0);
        out_rdy = 4'b0001;
        tick();
        chk("full_ignored", 32'(count), 4);
        chk("full_rdy_back", 32'(in_rdy), 1);
        for (int l = 0; l < 4; l++) begin
            lane(l, 4'(l + 10), 32'h200 + 32'(l), 3'd0, 1'b0);
            push(4'(l + 10), 32'h200 + 32'(l));
        end
        tick();
        chk("full_c8", 32'(count), 8);
        chk("full_flag8", 32'(buffer_full), 1);
        chk("full_rdy8", 32'(in_rdy), 0);
        out_rdy = '1;
        tick();
        chk("full_dr4", 32'(count), 4);
        out_rdy = '1;
        tick();
        chk("full_dr0", 32'(count), 0);
        chk("full_empty", 32'(buffer_empty), 1);

        // flush with simultaneous drain attempt and accept
        lane(0, 4'd1, 32'h41, 3'd1, 1'b0);
        lane(1, 4'd2, 32'h42, 3'd2, 1'b0);
        lane(2, 4'd3, 32'h43, 3'd1, 1'b0);
        lane(3, 4'd4, 32'h44, 3'd3, 1'b0);
        tick();
        chk("fl_count4", 32'(count), 4);
        flush_en = 1'b1; flush_id = 3'd1; out_rdy = 4'b0001;
        lane(0, 4'd7, 32'h47, 3'd1, 1'b0);
        lane(1, 4'd8, 32'h48, 3'd4, 1'b0);
        #1 chk("fl_out_vld", 32'(out_vld), 32'hA);
        tick();
        push(4'd2, 32'h42); push(4'd4, 32'h44); push(4'd8, 32'h48);
        chk("fl_count3", 32'(count), 3);
        chk("fl_order", 32'(out_des[11:0]), 32'h842);
        chk("fl_busy", 32'(reg_busy), 32'h0114);
        out_rdy = '1;
        tick();
        chk("fl_drained", 32'(count), 0);

        // load response hitting a flushed load
        lane(0, 4'd5, 32'h0, 3'd6, 1'b1);
        tick();
        chk("fld_count1", 32'(count), 1);
        load_done = 1'b1; load_data = 32'hDEAD; flush_en = 1'b1; flush_id = 3'd6;
        tick();
        chk("fld_gone", 32'(count), 0);
        chk("fld_empty", 32'(buffer_empty), 1);
        lane(0, 4'd7, 32'h0, 3'd0, 1'b1);
        tick();
        chk("fld_pending", 32'(out_vld), 0);
        chk("fld_busy7", 32'(reg_busy), 32'h0080);
        load_done = 1'b1; load_data = 32'hBEEF;
        push(4'd7, 32'hBEEF);
        tick();
        chk("fld_filled", 32'(out_vld), 32'h1);
        chk("fld_data", out_data[31:0], 32'hBEEF);
        out_rdy = '1;
        tick();

        // asynchronous reset mid-fill, stale load response afterwards
        lane(0, 4'd1, 32'h61, 3'd0, 1'b0);
        lane(1, 4'd2, 32'h0, 3'd0, 1'b1);
        lane(2, 4'd3, 32'h63, 3'd0, 1'b0);
        tick();
        chk("ar_count3", 32'(count), 3);
        #2 rst = 1'b1;
        #1;
        chk("ar_count", 32'(count), 0);
        chk("ar_empty", 32'(buffer_empty), 1);
        chk("ar_busy", 32'(reg_busy), 0);
        chk("ar_out_vld", 32'(out_vld), 0);
        chk("ar_in_rdy", 32'(in_rdy), 1);
        @(posedge clk);
        #1 rst = 1'b0;
        load_done = 1'b1; load_data = 32'h7777;
        tick();
        chk("ar_stale_ld", 32'(count), 0);
        lane(0, 4'd9, 32'h99, 3'd0, 1'b0);
        push(4'd9, 32'h99);
        tick();
        chk("ar_new_vld", 32'(out_vld), 32'h1);
        out_rdy = '1;
        tick();
        chk("sb_empty", 32'(q_des.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/wb_result_buffer.md
Name: wb_result_buffer

Overview:
- Parametrised, in-order-retiring result buffer between the N-wide execute lanes and register writeback.
- Accepts up to LANES results per cycle and holds loads until their memory data returns.
- Drains up to LANES oldest completed entries per cycle, squashes entries by branch tag, and keeps a register-busy bitmap for RAW tracking.
- Collapsing queue: entry 0 is always the oldest entry.

Parameters:
- LANES, 4, number of input and output lanes.
- DEPTH, 8, number of buffer entries; must be >= LANES.
- DATA_W, 32, result data width.
- DES_W, 4, destination register index width.
- BR_W, 3, branch tag width.
- REG_NUM, 16, architectural register count; equals 2**DES_W.

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- in_vld  in  LANES  per-lane result valid
- in_des  in  LANES*DES_W  destination register, lane-packed
- in_data  in  LANES*DATA_W  ALU result; don't-care for loads
- in_branch  in  LANES*BR_W  branch tag
- in_is_load  in  LANES  entry waits for load_data
- in_rdy  out  1  buffer can take a full LANES group this cycle
- load_done  in  1  memory response valid
- load_data  in  DATA_W  memory response data
- flush_en  in  1  squash request
- flush_id  in  BR_W  tag to squash
- out_vld  out  LANES  drainable entry on lane k
- out_des  out  LANES*DES_W  destination of entry k
- out_data  out  LANES*DATA_W  data of entry k
- out_rdy  in  LANES  consumer accepts lane k
- buffer_full  out  1  count > DEPTH-LANES
- buffer_empty  out  1  count == 0
- count  out  $clog2(DEPTH+1)  occupied entries
- reg_busy  out  REG_NUM  OR of one-hot destinations of all held entries

Behaviour:
- Reset (async, rst=1):
  - all entries invalid; count=0; out_vld=0; buffer_empty=1; buffer_full=0; reg_busy=0; in_rdy=1.
  - Reset mid-operation discards all contents, including pending loads; a load_done after reset is ignored.
- Entry fields: vld, done, des, data, branch.
  - Non-load entries are written with done=1.
  - Loads are written with done=0.
- Accept:
  - in_rdy = (DEPTH-count >= LANES), computed from registered count only.
  - When in_rdy=1, valid lanes are appended in lane order (lane 0 first) behind survivors; invalid lanes leave no holes.
  - When in_rdy=0, inputs are ignored; upstream must hold them.
- Output (combinational from state):
  - out_vld[k]=1 iff entries 0..k are all vld and done.
  - A lane is also masked if flush_en and its tag equals flush_id.
- Drain:
  - Lane k retires iff out_vld[k] and out_rdy[k] and every lower lane retires (prefix).
  - A gap stops draining at that lane.
- Load fill:
  - load_done writes load_data into the oldest entry with done=0 and sets done.
  - The entry is drainable the next cycle (1-cycle latency, no bypass).
  - If no pending load exists, or the target is flushed the same cycle, the response is consumed and dropped.
- Flush:
  - With flush_en, every entry and every incoming lane whose tag == flush_id is removed at the edge.
  - Order of the remaining entries is preserved.
- Next-state order within one edge: load fill, drain, flush, compaction of survivors, append of accepted lanes.
  - Simultaneous drain+flush+accept is legal.
  - count_next = survivors + accepted; it never exceeds DEPTH by construction.
- reg_busy:
  - Recomputed from registered entries.
  - A destination is busy while any entry targeting it is held; it clears the cycle after its last holder leaves.
- Flags and counter are registered-state derived and glitch-free; no combinational path from in_* to out_*.

Decomposition:
- Package wb_pkg: entry struct typedef (vld, done, des, data, branch) and a function for one-hot decode of des.
- Sub-module wb_compact (combinational):
  - Inputs: DEPTH keep-mask plus LANES append-mask.
  - Output: prefix-sum gather producing next entry array and next count.
  - Shared by the flush/drain collapse path and the append path.

Test Plan:
- Reset mid-fill: 3 entries held, pulse rst -> count=0, buffer_empty=1, reg_busy=0 immediately (async), out_vld=0.
- Compaction: write lanes {1,3} with des 5,9 and data 0xA,0xB -> count=2; out_vld=0011; out_des lane0=5, lane1=9; reg_busy bits 5 and 9 set.
- Load ordering: write load(des 2) then ALU(des 3) -> out_vld=00; assert load_done with data 0x1234 -> next cycle out_vld=0011, lane0 data=0x1234; out_rdy=0001 -> count=1, des 3 remains.
- Full/backpressure: DEPTH=8, fill to count=5 -> in_rdy=0, buffer_full=1; drain 1 -> in_rdy=1 next cycle; accept 4 -> count=8.
- Flush with simultaneous traffic: entries tags 1,2,1,3; flush_id=1, drain lane0 not possible (masked), accept 2 lanes tag 1 and 4 -> survivors tags 2,3,4, count=3, order preserved.
- Load response to flushed load: single pending load tag 6 flushed same cycle as load_done -> entry gone, data dropped, next load written later stays done=0.
